// File: rtl/layer_compositor.sv
// layer_compositor
//   Priority-selects one of four RGB444 layers (bit 0 wins) or the background
//   for the current pixel, scales the chosen colour by a global brightness
//   driven by a frame-stepped fade FSM, and registers the result (1-cycle
//   latency).
//
// Optional feature (macro COLLISION_DETECT_EN):
//   defined   - frame-latched flag of layer 0 overlapping any of layers 1..3
//   undefined - collision tied to 0
//
// Ports
//   clk_25       in   1   pixel clock, rising edge
//   reset        in   1   synchronous, active-high
//   pxl_x/pxl_y  in  32   current pixel column/row; (0,0) marks frame start
//   layer_draw   in   4   per-layer draw request, bit 0 highest priority
//   layer_rgb    in  48   layer n colour at [12n+11:12n], R[11:8] G[7:4] B[3:0]
//   bg_rgb       in  12   background colour
//   fade_cmd     in   2   00 hold, 01 fade-in, 10 fade-out, 11 ignored
//   Red_level    out  4   composited red
//   Green_level  out  4   composited green
//   Blue_level   out  4   composited blue
//   layer_id     out  3   winning source, 0-3 layer, 4 background
//   fade_busy    out  1   high while fading in or out
//   collision    out  1   frame-latched collision flag
module layer_compositor (
  input  logic        clk_25,
  input  logic        reset,
  input  logic [31:0] pxl_x,
  input  logic [31:0] pxl_y,
  input  logic [3:0]  layer_draw,
  input  logic [47:0] layer_rgb,
  input  logic [11:0] bg_rgb,
  input  logic [1:0]  fade_cmd,
  output logic [3:0]  Red_level,
  output logic [3:0]  Green_level,
  output logic [3:0]  Blue_level,
  output logic [2:0]  layer_id,
  output logic        fade_busy,
  output logic        collision
);

  typedef enum logic [1:0] {
    SHOWN,
    FADING_OUT,
    DARK,
    FADING_IN
  } fade_state_t;

  fade_state_t r_state;
  fade_state_t w_state_cmd;
  fade_state_t w_state_nxt;
  logic [3:0]  r_bright;
  logic [3:0]  w_bright_nxt;
  logic        w_frame_start;

  logic [11:0] w_sel_rgb;
  logic [2:0]  w_sel_id;
  logic [4:0]  w_gain;

  // out = (c * (bright + 1)) >> 4, product fits in 9 bits
  function automatic logic [3:0] f_scale(input logic [3:0] c, input logic [4:0] g);
    return 4'((9'(c) * 9'(g)) >> 4);
  endfunction

  assign w_frame_start = (pxl_x == 32'd0) && (pxl_y == 32'd0);

  // Command is applied first; a coincident frame_start then steps in the
  // direction of the post-command state.
  always_comb begin
    w_state_cmd  = r_state;
    case (r_state)
      SHOWN:      if (fade_cmd == 2'b10) w_state_cmd = FADING_OUT;
      FADING_OUT: if (fade_cmd == 2'b01) w_state_cmd = FADING_IN;
      DARK:       if (fade_cmd == 2'b01) w_state_cmd = FADING_IN;
      FADING_IN:  if (fade_cmd == 2'b10) w_state_cmd = FADING_OUT;
      default:    w_state_cmd = r_state;
    endcase

    w_state_nxt  = w_state_cmd;
    w_bright_nxt = r_bright;
    if (w_frame_start) begin
      if (w_state_cmd == FADING_OUT) begin
        if (r_bright > 4'd1) begin
          w_bright_nxt = r_bright - 4'd1;
        end else begin
          w_bright_nxt = '0;
          w_state_nxt  = DARK;
        end
      end else if (w_state_cmd == FADING_IN) begin
        if (r_bright < 4'd14) begin
          w_bright_nxt = r_bright + 4'd1;
        end else begin
          w_bright_nxt = '1;
          w_state_nxt  = SHOWN;
        end
      end
    end
  end

  always_ff @(posedge clk_25) begin
    if (reset) begin
      r_state  <= SHOWN;
      r_bright <= '1;
    end else begin
      r_state  <= w_state_nxt;
      r_bright <= w_bright_nxt;
    end
  end

  assign fade_busy = (r_state == FADING_OUT) || (r_state == FADING_IN);

  always_comb begin
    w_sel_rgb = bg_rgb;
    w_sel_id  = 3'd4;
    if (layer_draw[0]) begin
      w_sel_rgb = layer_rgb[11:0];
      w_sel_id  = 3'd0;
    end else if (layer_draw[1]) begin
      w_sel_rgb = layer_rgb[23:12];
      w_sel_id  = 3'd1;
    end else if (layer_draw[2]) begin
      w_sel_rgb = layer_rgb[35:24];
      w_sel_id  = 3'd2;
    end else if (layer_draw[3]) begin
      w_sel_rgb = layer_rgb[47:36];
      w_sel_id  = 3'd3;
    end
  end

  // Pixel uses the brightness registered at the start of this cycle.
  assign w_gain = {1'b0, r_bright} + 5'd1;

  always_ff @(posedge clk_25) begin
    if (reset) begin
      Red_level   <= '0;
      Green_level <= '0;
      Blue_level  <= '0;
      layer_id    <= 3'd4;
    end else begin
      Red_level   <= f_scale(w_sel_rgb[11:8], w_gain);
      Green_level <= f_scale(w_sel_rgb[7:4], w_gain);
      Blue_level  <= f_scale(w_sel_rgb[3:0], w_gain);
      layer_id    <= w_sel_id;
    end
  end

`ifdef COLLISION_DETECT_EN
  logic r_coll_flag;
  logic r_collision;
  logic w_hit;

  assign w_hit = layer_draw[0] & (|layer_draw[3:1]);

  // A hit on the frame_start cycle itself seeds the new frame's flag.
  always_ff @(posedge clk_25) begin
    if (reset) begin
      r_coll_flag <= 1'b0;
      r_collision <= 1'b0;
    end else if (w_frame_start) begin
      r_collision <= r_coll_flag;
      r_coll_flag <= w_hit;
    end else begin
      r_coll_flag <= r_coll_flag | w_hit;
    end
  end

  assign collision = r_collision;
`else
  assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_layer_compositor.sv
module tb_layer_compositor;

  logic        clk_25 = 1'b0;
  logic        reset;
  logic [31:0] pxl_x;
  logic [31:0] pxl_y;
  logic [3:0]  layer_draw;
  logic [47:0] layer_rgb;
  logic [11:0] bg_rgb;
  logic [1:0]  fade_cmd;
  logic [3:0]  Red_level;
  logic [3:0]  Green_level;
  logic [3:0]  Blue_level;
  logic [2:0]  layer_id;
  logic        fade_busy;
  logic        collision;

  layer_compositor dut (
    .clk_25      (clk_25),
    .reset       (reset),
    .pxl_x       (pxl_x),
    .pxl_y       (pxl_y),
    .layer_draw  (layer_draw),
    .layer_rgb   (layer_rgb),
    .bg_rgb      (bg_rgb),
    .fade_cmd    (fade_cmd),
    .Red_level   (Red_level),
    .Green_level (Green_level),
    .Blue_level  (Blue_level),
    .layer_id    (layer_id),
    .fade_busy   (fade_busy),
    .collision   (collision)
  );

  always #20 clk_25 = ~clk_25;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode numbers are the bench's own bookkeeping
  localparam int M_SHOWN = 0;
  localparam int M_OUT   = 1;
  localparam int M_DARK  = 2;
  localparam int M_IN    = 3;

  int m_mode   = M_SHOWN;
  int m_bright = 15;
  int m_flag   = 0;
  int e_r = 0, e_g = 0, e_b = 0, e_id = 4, e_busy = 0, e_coll = 0;

  task automatic model_step();
    int     win;
    int     col;
    bit     fs;
    bit     hit;
    fs  = (pxl_x == 0) && (pxl_y == 0);
    hit = layer_draw[0] && (layer_draw[3:1] != 3'b000);
    if (reset) begin
      m_mode = M_SHOWN; m_bright = 15; m_flag = 0;
      e_r = 0; e_g = 0; e_b = 0; e_id = 4; e_coll = 0;
    end else begin
      win = 4;
      col = int'(bg_rgb);
      for (int i = 3; i >= 0; i--) begin
        if (layer_draw[i]) begin
          win = i;
          col = int'(layer_rgb[12*i +: 12]);
        end
      end
      e_id = win;
      e_r  = ((col / 256) % 16) * (m_bright + 1) / 16;
      e_g  = ((col / 16) % 16) * (m_bright + 1) / 16;
      e_b  = (col % 16) * (m_bright + 1) / 16;

      if (fade_cmd == 2'b10 && (m_mode == M_SHOWN || m_mode == M_IN)) m_mode = M_OUT;
      else if (fade_cmd == 2'b01 && (m_mode == M_DARK || m_mode == M_OUT)) m_mode = M_IN;
      if (fs) begin
        if (m_mode == M_OUT) begin
          m_bright = (m_bright > 0) ? m_bright - 1 : 0;
          if (m_bright == 0) m_mode = M_DARK;
        end else if (m_mode == M_IN) begin
          m_bright = (m_bright < 15) ? m_bright + 1 : 15;
          if (m_bright == 15) m_mode = M_SHOWN;
        end
      end
`ifdef COLLISION_DETECT_EN
      if (fs) begin
        e_coll = m_flag;
        m_flag = hit ? 1 : 0;
      end else if (hit) begin
        m_flag = 1;
      end
`else
      e_coll = 0;
`endif
    end
    e_busy = (m_mode == M_OUT || m_mode == M_IN) ? 1 : 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("red",       32'(Red_level),   32'(e_r));
    chk("green",     32'(Green_level), 32'(e_g));
    chk("blue",      32'(Blue_level),  32'(e_b));
    chk("layer_id",  32'(layer_id),    32'(e_id));
    chk("fade_busy", 32'(fade_busy),   32'(e_busy));
    chk("collision", 32'(collision),   32'(e_coll));
  endtask

  task automatic step();
    @(posedge clk_25);
    model_step();
    @(negedge clk_25);
    check_all();
  endtask

  task automatic rand_pix();
    layer_draw = 4'($urandom);
    layer_rgb  = {16'($urandom), 32'($urandom)};
    bg_rgb     = 12'($urandom);
    pxl_x      = $urandom_range(1, 799);
    pxl_y      = $urandom_range(0, 524);
    fade_cmd   = 2'b00;
  endtask

  task automatic clean_pix();
    rand_pix();
    layer_draw = layer_draw & 4'b1110;
  endtask

  task automatic do_frame();
    rand_pix();
    pxl_x = 0;
    pxl_y = 0;
    step();
    repeat (3) begin
      rand_pix();
      step();
    end
  endtask

  task automatic full_white();
    rand_pix();
    layer_draw       = 4'b0001;
    layer_rgb[11:0]  = 12'hFFF;
  endtask

  logic [31:0] exp_coll_hi;

  initial begin
`ifdef COLLISION_DETECT_EN
    exp_coll_hi = 32'd1;
`else
    exp_coll_hi = 32'd0;
`endif
    reset = 1'b1;
    rand_pix();
    @(negedge clk_25);
    step();
    step();
    chk("rst_red",  32'(Red_level), 32'd0);
    chk("rst_id",   32'(layer_id),  32'd4);
    chk("rst_busy", 32'(fade_busy), 32'd0);
    chk("rst_coll", 32'(collision), 32'd0);
    reset = 1'b0;

    // Priority
    rand_pix();
    layer_draw         = 4'b0110;
    layer_rgb[23:12]   = 12'hF00;
    layer_rgb[35:24]   = 12'h0F0;
    step();
    chk("prio_r",  32'(Red_level),   32'hF);
    chk("prio_g",  32'(Green_level), 32'h0);
    chk("prio_b",  32'(Blue_level),  32'h0);
    chk("prio_id", 32'(layer_id),    32'd1);
    layer_draw = 4'b0000;
    bg_rgb     = 12'h123;
    step();
    chk("bg_r",  32'(Red_level),   32'h1);
    chk("bg_g",  32'(Green_level), 32'h2);
    chk("bg_b",  32'(Blue_level),  32'h3);
    chk("bg_id", 32'(layer_id),    32'd4);

    repeat (100) begin
      rand_pix();
      if ($urandom_range(0, 7) == 0) begin
        pxl_x = 0;
        pxl_y = 0;
      end
      step();
    end

    // Fade out to DARK
    rand_pix();
    fade_cmd = 2'b10;
    step();
    chk("fo_busy_start", 32'(fade_busy), 32'd1);
    repeat (7) do_frame();
    full_white();
    step();
    chk("fo_after7_red", 32'(Red_level), 32'd8);
    repeat (8) do_frame();
    chk("fo_dark_busy", 32'(fade_busy), 32'd0);
    full_white();
    step();
    chk("fo_dark_red", 32'(Red_level), 32'd0);

    // Fade back in to SHOWN
    rand_pix();
    fade_cmd = 2'b01;
    step();
    repeat (15) do_frame();
    chk("fi_shown_busy", 32'(fade_busy), 32'd0);

    // Reversal at bright 10
    rand_pix();
    fade_cmd = 2'b10;
    step();
    repeat (5) do_frame();
    full_white();
    step();
    chk("rev_b10_red", 32'(Red_level), 32'd10);
    rand_pix();
    fade_cmd = 2'b01;
    step();
    chk("rev_busy", 32'(fade_busy), 32'd1);
    repeat (4) do_frame();
    chk("rev_busy4", 32'(fade_busy), 32'd1);
    do_frame();
    chk("rev_done_busy", 32'(fade_busy), 32'd0);
    full_white();
    step();
    chk("rev_done_red", 32'(Red_level), 32'hF);

    // Command coinciding with frame_start
    rand_pix();
    pxl_x    = 0;
    pxl_y    = 0;
    fade_cmd = 2'b10;
    step();
    full_white();
    step();
    chk("simul_red", 32'(Red_level), 32'd14);

    // Reset mid-fade at bright 6
    repeat (8) do_frame();
    full_white();
    step();
    chk("mid_b6_red", 32'(Red_level), 32'd6);
    reset = 1'b1;
    full_white();
    step();
    chk("midrst_red",  32'(Red_level), 32'd0);
    chk("midrst_id",   32'(layer_id),  32'd4);
    chk("midrst_busy", 32'(fade_busy), 32'd0);
    reset = 1'b0;
    full_white();
    step();
    chk("postrst_red",  32'(Red_level), 32'hF);
    chk("postrst_busy", 32'(fade_busy), 32'd0);

    // Collision
    clean_pix();
    pxl_x = 0;
    pxl_y = 0;
    step();
    clean_pix();
    layer_draw = 4'b0011;
    step();
    repeat (3) begin
      clean_pix();
      step();
    end
    clean_pix();
    pxl_x = 0;
    pxl_y = 0;
    step();
    chk("coll_set", 32'(collision), exp_coll_hi);
    repeat (3) begin
      clean_pix();
      step();
    end
    clean_pix();
    pxl_x = 0;
    pxl_y = 0;
    step();
    chk("coll_clear", 32'(collision), 32'd0);

    // Random mix of commands, frames and occasional reset
    repeat (1500) begin
      rand_pix();
      fade_cmd = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) begin
        pxl_x = 0;
        pxl_y = 0;
      end
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
